// File: rtl/parking_exit_gate.sv
// parking_exit_gate
// Exit-side gate controller and owner of the lot occupancy counter.
// A car at the exit waits WAIT_CYCLES cycles. Its 2-field exit code is then checked.
// A correct code opens the gate. Occupancy drops by one when the car clears the gate.
// Entrance admissions arrive as car_entered pulses.
// Optional feature macro: EXIT_GATE_TIMEOUT_EN
//   When the macro is defined, the gate closes after GATE_TIMEOUT cycles if no car passes.
//   Occupancy is not changed when the gate closes this way.
module parking_exit_gate #(
  parameter int         CAPACITY     = 8,
  parameter int         OCC_W        = 4,
  parameter logic [1:0] CODE_1       = 2'b10,
  parameter logic [1:0] CODE_2       = 2'b01,
  parameter int         WAIT_CYCLES  = 4,
  parameter int         GATE_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sensor_exit_approach,
  input  logic             sensor_exit_clear,
  input  logic [1:0]       exit_code_1,
  input  logic [1:0]       exit_code_2,
  input  logic             car_entered,
  output logic             gate_open,
  output logic             GREEN_LED,
  output logic             RED_LED,
  output logic [OCC_W-1:0] occupancy,
  output logic             lot_full,
  output logic             lot_empty
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_CODE  = 2'd1,
    WRONG_CODE = 2'd2,
    GATE_OPEN  = 2'd3
  } state_t;

  localparam int               WC_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(WAIT_CYCLES - 1);
  localparam logic [WC_W-1:0]  WC_ONE    = WC_W'(1);
  localparam logic [OCC_W-1:0] OCC_MAX   = OCC_W'(CAPACITY);
  localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);

  // Refuse to elaborate with a counter too narrow for CAPACITY or with zero-length waits.
  if ((WAIT_CYCLES < 1) || (GATE_TIMEOUT < 1) || ((1 << OCC_W) <= CAPACITY)) begin : g_param_check
    $error("parking_exit_gate: illegal parameter combination");
  end

  state_t            state_r;
  state_t            next_state_s;
  logic [WC_W-1:0]   wait_cnt_r;
  logic [OCC_W-1:0]  occ_r;
  logic              green_r;
  logic              red_r;
  logic              match_s;
  logic              lot_full_s;
  logic              lot_empty_s;
  logic              inc_s;
  logic              dec_s;
  logic              timeout_s;

  assign match_s     = (exit_code_1 == CODE_1) && (exit_code_2 == CODE_2);
  assign lot_full_s  = (occ_r == OCC_MAX);
  assign lot_empty_s = (occ_r == {OCC_W{1'b0}});

  // A full lot drops the entry pulse. An empty lot cannot lose a car.
  assign inc_s = car_entered && !lot_full_s;
  assign dec_s = (state_r == GATE_OPEN) && sensor_exit_clear && !lot_empty_s;

`ifdef EXIT_GATE_TIMEOUT_EN
  localparam int              TO_W    = $clog2(GATE_TIMEOUT) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(GATE_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [TO_W-1:0] to_cnt_r;

  // Count the cycles spent in GATE_OPEN. The counter sits at zero in every other state, so it starts fresh on entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else if (state_r != GATE_OPEN) begin
      to_cnt_r <= {TO_W{1'b0}};
    end else begin
      to_cnt_r <= to_cnt_r + TO_ONE;
    end
  end

  assign timeout_s = (state_r == GATE_OPEN) && (to_cnt_r == TO_LAST);
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic. A car clearing the gate takes priority over the timeout.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (sensor_exit_approach && !lot_empty_s) begin
          next_state_s = WAIT_CODE;
        end else begin
          next_state_s = IDLE;
        end
      end
      WAIT_CODE: begin
        if (wait_cnt_r == WAIT_LAST) begin
          if (match_s) begin
            next_state_s = GATE_OPEN;
          end else begin
            next_state_s = WRONG_CODE;
          end
        end else begin
          next_state_s = WAIT_CODE;
        end
      end
      WRONG_CODE: begin
        if (match_s) begin
          next_state_s = GATE_OPEN;
        end else if (!sensor_exit_approach) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = WRONG_CODE;
        end
      end
      GATE_OPEN: begin
        if (sensor_exit_clear) begin
          next_state_s = IDLE;
        end else if (timeout_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = GATE_OPEN;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Code-wait counter. It is held at zero in IDLE, so every WAIT_CODE visit starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_r <= {WC_W{1'b0}};
    end else if (state_r == IDLE) begin
      wait_cnt_r <= {WC_W{1'b0}};
    end else if (state_r == WAIT_CODE) begin
      wait_cnt_r <= wait_cnt_r + WC_ONE;
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Saturating occupancy counter. An entry and an exit on the same edge cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_r <= {OCC_W{1'b0}};
    end else if (inc_s && !dec_s) begin
      occ_r <= occ_r + OCC_ONE;
    end else if (dec_s && !inc_s) begin
      occ_r <= occ_r - OCC_ONE;
    end else begin
      occ_r <= occ_r;
    end
  end

  // Status LEDs are registered from the current state, so they lag it by one cycle. Red blinks in WRONG_CODE.
  always_ff @(posedge clk) begin
    if (reset) begin
      green_r <= 1'b0;
      red_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          green_r <= 1'b0;
          red_r   <= 1'b0;
        end
        WAIT_CODE: begin
          green_r <= 1'b0;
          red_r   <= 1'b1;
        end
        WRONG_CODE: begin
          green_r <= 1'b0;
          red_r   <= ~red_r;
        end
        GATE_OPEN: begin
          green_r <= 1'b1;
          red_r   <= 1'b0;
        end
        default: begin
          green_r <= 1'b0;
          red_r   <= 1'b0;
        end
      endcase
    end
  end

  assign gate_open = (state_r == GATE_OPEN);
  assign GREEN_LED = green_r;
  assign RED_LED   = red_r;
  assign occupancy = occ_r;
  assign lot_full  = lot_full_s;
  assign lot_empty = lot_empty_s;

endmodule

// File: tb/tb_parking_exit_gate.sv
// Directed self-checking bench for parking_exit_gate (default parameters).
// Compile with the same EXIT_GATE_TIMEOUT_EN setting as the RTL.
module tb_parking_exit_gate;

  logic       clk = 1'b0;
  logic       reset;
  logic       sensor_exit_approach;
  logic       sensor_exit_clear;
  logic [1:0] exit_code_1;
  logic [1:0] exit_code_2;
  logic       car_entered;
  logic       gate_open;
  logic       GREEN_LED;
  logic       RED_LED;
  logic [3:0] occupancy;
  logic       lot_full;
  logic       lot_empty;

  int checks = 0;
  int errors = 0;

  parking_exit_gate dut (
    .clk                  (clk),
    .reset                (reset),
    .sensor_exit_approach (sensor_exit_approach),
    .sensor_exit_clear    (sensor_exit_clear),
    .exit_code_1          (exit_code_1),
    .exit_code_2          (exit_code_2),
    .car_entered          (car_entered),
    .gate_open            (gate_open),
    .GREEN_LED            (GREEN_LED),
    .RED_LED              (RED_LED),
    .occupancy            (occupancy),
    .lot_full             (lot_full),
    .lot_empty            (lot_empty)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and return at the following falling edge, where outputs are sampled.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  task automatic enter_cars(input int n);
    car_entered = 1'b1;
    tick(n);
    car_entered = 1'b0;
  endtask

  // Present the correct code and wait until the gate has just opened (4 edges after approach is sampled).
  task automatic open_gate();
    exit_code_1 = 2'b10;
    exit_code_2 = 2'b01;
    sensor_exit_approach = 1'b1;
    tick(5);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL reset_gate_open got %0b exp 0", gate_open); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
    checks++; if (lot_empty !== 1'b1) begin errors++; $display("FAIL reset_lot_empty got %0b exp 1", lot_empty); end
    checks++; if (lot_full !== 1'b0) begin errors++; $display("FAIL reset_lot_full got %0b exp 0", lot_full); end
    checks++; if ({GREEN_LED, RED_LED} !== 2'b00) begin errors++; $display("FAIL reset_leds got %b exp 00", {GREEN_LED, RED_LED}); end
  endtask

  task automatic test_entries();
    // Approach with an empty lot must be ignored even with the right code.
    exit_code_1 = 2'b10;
    exit_code_2 = 2'b01;
    sensor_exit_approach = 1'b1;
    tick(6);
    checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL empty_approach_gate got %0b exp 0", gate_open); end
    checks++; if (RED_LED !== 1'b0) begin errors++; $display("FAIL empty_approach_red got %0b exp 0", RED_LED); end
    sensor_exit_approach = 1'b0;
    for (int i = 0; i < 3; i++) begin
      car_entered = 1'b1;
      tick(1);
      car_entered = 1'b0;
      tick(1);
    end
    checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL entries_occupancy got %0d exp 3", occupancy); end
    checks++; if (lot_empty !== 1'b0) begin errors++; $display("FAIL entries_lot_empty got %0b exp 0", lot_empty); end
  endtask

  task automatic test_correct_code();
    exit_code_1 = 2'b10;
    exit_code_2 = 2'b01;
    sensor_exit_approach = 1'b1;
    tick(1);
    for (int e = 1; e <= 3; e++) begin
      tick(1);
      checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL wait_gate_edge%0d got %0b exp 0", e, gate_open); end
      checks++; if (RED_LED !== 1'b1) begin errors++; $display("FAIL wait_red_edge%0d got %0b exp 1", e, RED_LED); end
    end
    tick(1);
    checks++; if (gate_open !== 1'b1) begin errors++; $display("FAIL open_gate_edge4 got %0b exp 1", gate_open); end
    checks++; if (GREEN_LED !== 1'b0) begin errors++; $display("FAIL open_green_lag got %0b exp 0", GREEN_LED); end
    tick(1);
    checks++; if ({GREEN_LED, RED_LED} !== 2'b10) begin errors++; $display("FAIL open_leds got %b exp 10", {GREEN_LED, RED_LED}); end
    sensor_exit_approach = 1'b0;
    sensor_exit_clear = 1'b1;
    tick(1);
    sensor_exit_clear = 1'b0;
    checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL pass_gate got %0b exp 0", gate_open); end
    checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL pass_occupancy got %0d exp 2", occupancy); end
    tick(1);
    checks++; if (GREEN_LED !== 1'b0) begin errors++; $display("FAIL pass_green got %0b exp 0", GREEN_LED); end
  endtask

  task automatic test_wrong_then_right();
    logic [2:0] exp_red;
    exit_code_1 = 2'b00;
    exit_code_2 = 2'b00;
    sensor_exit_approach = 1'b1;
    tick(5);
    checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL wrong_gate got %0b exp 0", gate_open); end
    // After the edges that follow entry into WRONG_CODE, red reads 0, 1, 0 in turn.
    exp_red = 3'b010;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++; if (RED_LED !== exp_red[2-i]) begin errors++; $display("FAIL wrong_blink%0d got %0b exp %0b", i, RED_LED, exp_red[2-i]); end
    end
    exit_code_1 = 2'b10;
    exit_code_2 = 2'b01;
    tick(1);
    checks++; if (gate_open !== 1'b1) begin errors++; $display("FAIL right_after_wrong_gate got %0b exp 1", gate_open); end
    sensor_exit_approach = 1'b0;
    sensor_exit_clear = 1'b1;
    tick(1);
    sensor_exit_clear = 1'b0;
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL wrong_pass_occupancy got %0d exp 1", occupancy); end
  endtask

  task automatic test_withdraw();
    exit_code_1 = 2'b00;
    exit_code_2 = 2'b00;
    sensor_exit_approach = 1'b1;
    tick(5);
    sensor_exit_approach = 1'b0;
    tick(1);
    // The block must now be in IDLE. A correct code without an approaching car must not open the gate.
    exit_code_1 = 2'b10;
    exit_code_2 = 2'b01;
    tick(2);
    checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL withdraw_gate got %0b exp 0", gate_open); end
    checks++; if (RED_LED !== 1'b0) begin errors++; $display("FAIL withdraw_red got %0b exp 0", RED_LED); end
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL withdraw_occupancy got %0d exp 1", occupancy); end
  endtask

  task automatic test_saturation();
    enter_cars(6);
    checks++; if (occupancy !== 4'd7) begin errors++; $display("FAIL sat_partial_occupancy got %0d exp 7", occupancy); end
    checks++; if (lot_full !== 1'b0) begin errors++; $display("FAIL sat_partial_full got %0b exp 0", lot_full); end
    enter_cars(3);
    checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL sat_occupancy got %0d exp 8", occupancy); end
    checks++; if (lot_full !== 1'b1) begin errors++; $display("FAIL sat_lot_full got %0b exp 1", lot_full); end
  endtask

  task automatic test_simultaneous();
    // At full capacity, an entry on the pass edge is dropped, so only the exit counts.
    open_gate();
    sensor_exit_approach = 1'b0;
    sensor_exit_clear = 1'b1;
    car_entered = 1'b1;
    tick(1);
    sensor_exit_clear = 1'b0;
    car_entered = 1'b0;
    checks++; if (occupancy !== 4'd7) begin errors++; $display("FAIL full_pass_occupancy got %0d exp 7", occupancy); end
    // Below capacity, an entry and an exit on the same edge cancel out.
    open_gate();
    sensor_exit_approach = 1'b0;
    sensor_exit_clear = 1'b1;
    car_entered = 1'b1;
    tick(1);
    sensor_exit_clear = 1'b0;
    car_entered = 1'b0;
    checks++; if (occupancy !== 4'd7) begin errors++; $display("FAIL simul_occupancy got %0d exp 7", occupancy); end
    checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL simul_gate got %0b exp 0", gate_open); end
  endtask

  task automatic test_reset_mid_open();
    do_reset();
    enter_cars(5);
    open_gate();
    tick(1);
    checks++; if ({gate_open, GREEN_LED, occupancy} !== {1'b1, 1'b1, 4'd5}) begin errors++; $display("FAIL preopen_state got %b exp 1_1_0101", {gate_open, GREEN_LED, occupancy}); end
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    sensor_exit_approach = 1'b0;
    checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL midreset_gate got %0b exp 0", gate_open); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL midreset_occupancy got %0d exp 0", occupancy); end
    checks++; if ({GREEN_LED, RED_LED} !== 2'b00) begin errors++; $display("FAIL midreset_leds got %b exp 00", {GREEN_LED, RED_LED}); end
    checks++; if (lot_empty !== 1'b1) begin errors++; $display("FAIL midreset_empty got %0b exp 1", lot_empty); end
  endtask

  task automatic test_gate_hold();
    enter_cars(2);
    open_gate();
    sensor_exit_approach = 1'b0;
`ifdef EXIT_GATE_TIMEOUT_EN
    // 16 cycles in GATE_OPEN: open after the entry edge and the next 15 edges, then closed.
    tick(15);
    checks++; if (gate_open !== 1'b1) begin errors++; $display("FAIL timeout_still_open got %0b exp 1", gate_open); end
    tick(1);
    checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL timeout_closed got %0b exp 0", gate_open); end
    checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL timeout_occupancy got %0d exp 2", occupancy); end
`else
    tick(40);
    checks++; if (gate_open !== 1'b1) begin errors++; $display("FAIL hold_open got %0b exp 1", gate_open); end
    sensor_exit_clear = 1'b1;
    tick(1);
    sensor_exit_clear = 1'b0;
    checks++; if (gate_open !== 1'b0) begin errors++; $display("FAIL hold_closed got %0b exp 0", gate_open); end
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL hold_occupancy got %0d exp 1", occupancy); end
`endif
  endtask

  initial begin
    reset = 1'b1;
    sensor_exit_approach = 1'b0;
    sensor_exit_clear = 1'b0;
    exit_code_1 = 2'b00;
    exit_code_2 = 2'b00;
    car_entered = 1'b0;
    test_reset();
    test_entries();
    test_correct_code();
    test_wrong_then_right();
    test_withdraw();
    test_saturation();
    test_simultaneous();
    test_reset_mid_open();
    test_gate_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_exit_gate.md
Name: parking_exit_gate

Overview:
- Exit-side counterpart of the lot's entrance gate controller; handles cars leaving the lot.
- A car at the exit presents a 2-field exit code. A correct code opens the gate. When the car passes, the lot occupancy count is decremented.
- Also owns the lot occupancy counter. The entrance side pulses car_entered; this block publishes occupancy, lot_full and lot_empty.

Parameters:
- CAPACITY, 8, maximum cars in lot
- OCC_W, 4, occupancy width; must satisfy 2^OCC_W > CAPACITY
- CODE_1, 2'b10, required exit_code_1
- CODE_2, 2'b01, required exit_code_2
- WAIT_CYCLES, 4, cycles spent in WAIT_CODE before the code is sampled (>=1)
- GATE_TIMEOUT, 16, max GATE_OPEN cycles without a pass (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- sensor_exit_approach  in  1  car present at exit
- sensor_exit_clear  in  1  car has passed the gate
- exit_code_1  in  2  exit code field 1
- exit_code_2  in  2  exit code field 2
- car_entered  in  1  one-cycle pulse from the entrance side per admitted car
- gate_open  out  1  gate actuator; high exactly while state==GATE_OPEN
- GREEN_LED  out  1  registered status LED
- RED_LED  out  1  registered status LED
- occupancy  out  OCC_W  cars currently in lot
- lot_full  out  1  occupancy==CAPACITY
- lot_empty  out  1  occupancy==0

Behaviour:
- Reset (one clk edge with reset=1):
  - state=IDLE; wait_cnt=0; occupancy=0.
  - GREEN_LED=0, RED_LED=0.
  - Resulting outputs: gate_open=0, lot_empty=1, lot_full=0.
  - Reset mid-operation discards the current transaction and the occupancy count.
- Code match: exit_code_1==CODE_1 && exit_code_2==CODE_2, evaluated combinationally in the current cycle.
- FSM, registered state with combinational next-state:
  - IDLE:
    - sensor_exit_approach && !lot_empty -> WAIT_CODE, with wait_cnt cleared to 0.
    - Approach while lot_empty is ignored; stay in IDLE.
  - WAIT_CODE:
    - wait_cnt increments every cycle.
    - In the cycle where wait_cnt==WAIT_CYCLES-1: match -> GATE_OPEN, else -> WRONG_CODE.
    - Otherwise stay in WAIT_CODE.
    - Net timing: gate_open rises WAIT_CYCLES edges after the edge that samples approach.
  - WRONG_CODE (evaluated every cycle):
    - match -> GATE_OPEN.
    - else !sensor_exit_approach -> IDLE (car withdrew).
    - else stay in WRONG_CODE.
  - GATE_OPEN:
    - sensor_exit_clear -> IDLE, and occupancy decrements on that same edge.
    - Otherwise stay in GATE_OPEN (see Optional Feature).
  - Any illegal state encoding -> IDLE.
- Occupancy, updated on the same edge as the state register:
  - inc = car_entered && !lot_full.
  - dec = (state==GATE_OPEN) && sensor_exit_clear && !lot_empty.
  - inc&&dec -> unchanged; inc only -> +1; dec only -> -1.
  - Saturates: never exceeds CAPACITY, never wraps below 0.
  - car_entered while full is dropped silently.
  - lot_full and lot_empty are combinational from occupancy.
- LEDs: registered from the current state, so they lag the state register by one clk.
  - IDLE: G=0, R=0.
  - WAIT_CODE: G=0, R=1.
  - WRONG_CODE: G=0, R toggles every cycle (blink).
  - GATE_OPEN: G=1, R=0.
- sensor_exit_clear outside GATE_OPEN has no effect.

Optional Feature:
- Macro: EXIT_GATE_TIMEOUT_EN.
- Defined:
  - A timeout counter clears on entry to GATE_OPEN and increments each GATE_OPEN cycle.
  - If GATE_TIMEOUT cycles elapse with no sensor_exit_clear -> IDLE, gate closes, occupancy unchanged.
  - If clear arrives in the same cycle as expiry, clear wins (decrement, -> IDLE).
- Undefined: no timeout counter is built; GATE_OPEN holds until sensor_exit_clear.

Test Plan:
- Reset and entries: reset, then 3 car_entered pulses -> occupancy=3, lot_empty=0; approach at occupancy 0 beforehand -> state stays IDLE, gate_open=0.
- Correct code: occupancy=3, codes 2'b10/2'b01, approach high -> RED_LED=1 during wait; gate_open=1 four edges after approach sampled; GREEN_LED=1 one edge later; clear pulse -> gate_open=0, occupancy=2.
- Wrong then right: codes 2'b00/2'b00 -> WRONG_CODE, RED_LED toggles each cycle; codes 2'b10/2'b01 -> GATE_OPEN next edge. Separately, approach dropped while in WRONG_CODE -> IDLE.
- Saturation and simultaneity: 9 car_entered pulses with CAPACITY=8 -> occupancy=8, lot_full=1; car_entered on the same edge as a gate pass -> occupancy unchanged.
- Reset mid-open: reset asserted in GATE_OPEN with occupancy=5 -> next edge gate_open=0, occupancy=0, both LEDs 0.
- EXIT_GATE_TIMEOUT_EN defined: GATE_OPEN held 16 cycles with no clear -> IDLE, occupancy unchanged. Undefined: gate_open stays 1 after 40 cycles.
